spi_flash_responder: RTL and testbench
======================================

# spi_flash_responder

Synthesizable SPI serial-flash responder (mode 0) that answers the SoC's flash master on `o_flash_sclk`/`o_flash_cs_n`/`o_flash_mosi` and drives `i_flash_miso`. It serves READ (0x03), RDID (0x9F) and RDSR (0x05) from an internal byte array loaded through a parallel port. It is placed in the SoC bench and FPGA top as the flash device, clocked by the system clock, and oversamples the SPI pins.

## Interface
- `MEM_BYTES`, 4096: byte array size; must be a power of two, ≤ 2^24.
- `JEDEC_ID`, 24'hEF4016: RDID response, MSB byte first.
- `clk`  in  1  system clock; must run at ≥ 8× SCLK.
- `reset_n`  in  1  reset; one clock domain, asynchronous, active-low.
- `i_sclk`  in  1  SPI clock from master; asynchronous to `clk`.
- `i_cs_n`  in  1  chip select, active-low; asynchronous.
- `i_mosi`  in  1  master-out data; asynchronous.
- `o_miso`  out  1  responder data; 0 whenever not shifting out.
- `i_load_we`  in  1  byte write strobe for array preload.
- `i_load_addr`  in  $clog2(MEM_BYTES)  preload byte address.
- `i_load_data`  in  8  preload byte.
- `o_busy`  out  1  high while a transaction is open (synchronized CS low).

## Operation
- Input sync: `i_sclk`, `i_cs_n` and `i_mosi` each pass through a 2-flop synchronizer. SCLK rise and fall are detected from the synchronized value plus one history flop. All actions happen on these detected edges.
- Mode 0: MOSI is sampled on the detected rise, MSB first. MISO is updated on the detected fall, MSB first.
- States:
  - IDLE → CMD when synchronized CS falls. The bit counter and shift register clear.
  - CMD: shift in 8 bits. On the 8th rise, 0x03 → ADDR, 0x9F → ID, 0x05 → STAT, any other opcode → IGNORE.
  - ADDR: shift in 24 bits. On the 24th rise, latch the address and issue an array read of `addr[$clog2(MEM_BYTES)-1:0]` (upper bits ignored, so the array aliases). Then → DATA.
  - DATA: on each fall with bit index 0, load the prefetched byte into the output shifter, drive bit 7, increment the address modulo MEM_BYTES, and issue the next array read. Other falls shift left. The burst continues indefinitely.
  - ID: output `JEDEC_ID[23:16]`, `[15:8]`, `[7:0]`, then repeat from `[23:16]`.
  - STAT: output 0x00 repeatedly (WIP=0, WEL=0).
  - IGNORE: MISO held 0, MOSI ignored.
- From any state, a synchronized CS rise goes to IDLE on that clk. Outputs then return to reset values, and any partial byte is discarded.
- Array: single-port read, registered output (1 clk), plus the load write port.
  - Load writes are accepted in any state.
  - If a load and an array read hit the same address in the same clk, the read returns the old byte.
- Bits received during DATA/ID/STAT are ignored.

## Timing
- Reset values: `o_miso`=0, `o_busy`=0, state IDLE, counters 0, address 0. The array contents are not reset.
- Pin-to-detect latency is 3 clk (2 sync flops plus the edge flop).
- `o_miso` changes 1 clk after a detected fall, which is ≤4 clk after the pin falls.
- With SCLK half-period ≥4 clk, MISO is stable before the master's next rising edge.
- First data bit: driven on the first fall after the 24th address rise. The array read issued at that rise completes 1 clk later, well before that fall.
- `o_busy` rises 3 clk after `i_cs_n` falls and drops 3 clk after it rises.
- A CS high pulse shorter than 2 clk may be missed. The master must hold CS high ≥4 clk between transactions.
- Reset asserted mid-transaction: immediate return to reset values. After reset releases, the responder waits in IDLE for a fresh CS fall. A CS already low at release is not a start; CS must go high and then low again.

## Test plan
- Preload bytes 0x10..0x13 = A5,5A,FF,00. Send 03 00 00 10 with SCLK=clk/10 and clock 32 more bits → MISO bytes A5 5A FF 00. `o_busy` is high throughout.
- Preload byte 0xFFF=0x3C, byte 0x000=0xC3. READ at address 0x000FFF for 2 bytes → 3C C3 (wrap). Repeat with address 0x001FFF → identical result (aliasing).
- Send 9F and clock 48 bits → EF 40 16 EF 40 16. Send 05 and clock 16 bits → 00 00.
- Send opcode 0xAB and clock 16 bits → MISO stays 0. CS high then READ at 0x10 → A5, proving recovery.
- Raise CS after 4 data bits of a READ at 0x10 → IDLE within 3 clk and `o_miso`=0. The next READ at 0x11 → 5A.
- Assert `reset_n` low mid-address → `o_miso`/`o_busy` go to 0 immediately. With CS held low across release, clocked bits produce no response. A CS toggle followed by a READ works.

Source files
------------

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-0 SPI serial-flash responder serving READ (03h),
// RDID (9Fh) and RDSR (05h) from a byte array preloaded over a parallel port.
// Ports:
//   clk, reset_n           system clock, async active-low reset
//   i_sclk, i_cs_n, i_mosi SPI pins from the master (asynchronous)
//   o_miso                 responder data, 0 when not shifting out
//   i_load_we/addr/data    array preload write port
//   o_busy                 high while a transaction is open
module spi_flash_responder #(
   parameter int          MEM_BYTES = 4096,
   parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         i_sclk,
   input  logic                         i_cs_n,
   input  logic                         i_mosi,
   output logic                         o_miso,
   input  logic                         i_load_we,
   input  logic [$clog2(MEM_BYTES)-1:0] i_load_addr,
   input  logic [7:0]                   i_load_data,
   output logic                         o_busy
);

   localparam int AW = $clog2(MEM_BYTES);
   // Input shifter is wide enough for an opcode or the used address bits.
   localparam int SW = (AW > 8) ? AW : 8;
   localparam logic [AW-1:0] ONE = AW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_ID,
      S_STAT,
      S_IGNORE
   } state_t;

   state_t        r_state, w_state_nx;

   logic          r_sclk_s1, r_sclk_s2, r_sclk_d;
   logic          r_cs_s1, r_cs_s2, r_cs_d;
   logic          r_mosi_s1, r_mosi_s2;

   logic [4:0]    r_bitcnt, w_bitcnt_nx;
   logic [SW-2:0] r_shift, w_shift_nx;
   logic [AW-1:0] r_addr, w_addr_nx;
   logic [7:0]    r_obyte, w_obyte_nx;
   logic          r_miso, w_miso_nx;
   logic [2:0]    r_idx, w_idx_nx;
   logic [1:0]    r_idsel, w_idsel_nx;

   logic [7:0]    r_mem [MEM_BYTES];
   logic [7:0]    r_rdata;
   logic          w_rd_en;
   logic [AW-1:0] w_rd_addr;

   logic          w_sclk_rise, w_sclk_fall;
   logic          w_cs_rise, w_cs_fall;
   logic [SW-1:0] w_shift_in;
   logic [AW-1:0] w_new_addr;
   logic [7:0]    w_src;
   logic          w_tx;

   // Synchronizers reset low: a CS already low at reset release never
   // produces a falling edge, so it cannot start a transaction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_d  <= 1'b0;
         r_cs_s1   <= 1'b0;
         r_cs_s2   <= 1'b0;
         r_cs_d    <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
      end else begin
         r_sclk_s1 <= i_sclk;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_d  <= r_sclk_s2;
         r_cs_s1   <= i_cs_n;
         r_cs_s2   <= r_cs_s1;
         r_cs_d    <= r_cs_s2;
         r_mosi_s1 <= i_mosi;
         r_mosi_s2 <= r_mosi_s1;
      end
   end

   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
   assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
   assign w_cs_rise   = r_cs_s2 & ~r_cs_d;
   assign w_cs_fall   = ~r_cs_s2 & r_cs_d;

   assign w_shift_in  = {r_shift, r_mosi_s2};
   assign w_new_addr  = w_shift_in[AW-1:0];

   // Array: write-first ordering is not used, so a same-clk read of the
   // address being loaded returns the old byte.
   always_ff @(posedge clk) begin
      if (i_load_we) begin
         r_mem[i_load_addr] <= i_load_data;
      end
      if (w_rd_en) begin
         r_rdata <= r_mem[w_rd_addr];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_addr   <= '0;
         r_obyte  <= '0;
         r_miso   <= 1'b0;
         r_idx    <= '0;
         r_idsel  <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_bitcnt <= w_bitcnt_nx;
         r_shift  <= w_shift_nx;
         r_addr   <= w_addr_nx;
         r_obyte  <= w_obyte_nx;
         r_miso   <= w_miso_nx;
         r_idx    <= w_idx_nx;
         r_idsel  <= w_idsel_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_bitcnt_nx = r_bitcnt;
      w_shift_nx  = r_shift;
      w_addr_nx   = r_addr;
      w_obyte_nx  = r_obyte;
      w_miso_nx   = r_miso;
      w_idx_nx    = r_idx;
      w_idsel_nx  = r_idsel;
      w_rd_en     = 1'b0;
      w_rd_addr   = r_addr + ONE;
      w_src       = 8'h00;
      w_tx        = 1'b0;

      if (w_cs_rise) begin
         w_state_nx  = S_IDLE;
         w_bitcnt_nx = '0;
         w_shift_nx  = '0;
         w_addr_nx   = '0;
         w_obyte_nx  = '0;
         w_miso_nx   = 1'b0;
         w_idx_nx    = '0;
         w_idsel_nx  = '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_cs_fall) begin
                  w_state_nx  = S_CMD;
                  w_bitcnt_nx = '0;
                  w_shift_nx  = '0;
                  w_addr_nx   = '0;
                  w_obyte_nx  = '0;
                  w_miso_nx   = 1'b0;
                  w_idx_nx    = '0;
                  w_idsel_nx  = '0;
               end
            end
            S_CMD: begin
               if (w_sclk_rise) begin
                  w_shift_nx  = w_shift_in[SW-2:0];
                  w_bitcnt_nx = r_bitcnt + 5'd1;
                  if (r_bitcnt == 5'd7) begin
                     w_bitcnt_nx = '0;
                     unique case (w_shift_in[7:0])
                        8'h03:   w_state_nx = S_ADDR;
                        8'h9F:   w_state_nx = S_ID;
                        8'h05:   w_state_nx = S_STAT;
                        default: w_state_nx = S_IGNORE;
                     endcase
                  end
               end
            end
            S_ADDR: begin
               if (w_sclk_rise) begin
                  w_shift_nx  = w_shift_in[SW-2:0];
                  w_bitcnt_nx = r_bitcnt + 5'd1;
                  if (r_bitcnt == 5'd23) begin
                     // Upper address bits fall off: the array aliases.
                     w_bitcnt_nx = '0;
                     w_addr_nx   = w_new_addr;
                     w_rd_en     = 1'b1;
                     w_rd_addr   = w_new_addr;
                     w_state_nx  = S_DATA;
                  end
               end
            end
            S_DATA: begin
               w_tx  = 1'b1;
               w_src = r_rdata;
               // r_addr tracks the byte held in r_rdata; prefetch the next.
               if (w_sclk_fall && r_idx == 3'd0) begin
                  w_addr_nx = r_addr + ONE;
                  w_rd_en   = 1'b1;
               end
            end
            S_ID: begin
               w_tx = 1'b1;
               unique case (r_idsel)
                  2'd0:    w_src = JEDEC_ID[23:16];
                  2'd1:    w_src = JEDEC_ID[15:8];
                  default: w_src = JEDEC_ID[7:0];
               endcase
               if (w_sclk_fall && r_idx == 3'd0) begin
                  w_idsel_nx = (r_idsel == 2'd2) ? 2'd0 : r_idsel + 2'd1;
               end
            end
            S_STAT: begin
               w_tx = 1'b1;
            end
            S_IGNORE: begin
               w_miso_nx = 1'b0;
            end
            default: begin
               w_state_nx = S_IDLE;
            end
         endcase
      end

      // Shared output shifter for DATA/ID/STAT: bit index 0 loads a byte.
      if (w_tx && w_sclk_fall) begin
         w_idx_nx = r_idx + 3'd1;
         if (r_idx == 3'd0) begin
            w_miso_nx  = w_src[7];
            w_obyte_nx = {w_src[6:0], 1'b0};
         end else begin
            w_miso_nx  = r_obyte[7];
            w_obyte_nx = {r_obyte[6:0], 1'b0};
         end
      end
   end

   assign o_miso = r_miso;
   assign o_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed bench acting as a mode-0 SPI master
// (SCLK = clk/10) against spi_flash_responder with hand-computed responses.
module tb_spi_flash_responder;

   logic        clk;
   logic        reset_n;
   logic        i_sclk;
   logic        i_cs_n;
   logic        i_mosi;
   logic        o_miso;
   logic        i_load_we;
   logic [11:0] i_load_addr;
   logic [7:0]  i_load_data;
   logic        o_busy;

   int   n_checks;
   int   n_fail;
   logic busy_lost;

   spi_flash_responder #(
      .MEM_BYTES(4096),
      .JEDEC_ID (24'hEF4016)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_sclk     (i_sclk),
      .i_cs_n     (i_cs_n),
      .i_mosi     (i_mosi),
      .o_miso     (o_miso),
      .i_load_we  (i_load_we),
      .i_load_addr(i_load_addr),
      .i_load_data(i_load_data),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic spi_bit(input logic b, output logic r);
      i_mosi = b;
      #50;
      i_sclk = 1'b1;
      r = o_miso;
      if (o_busy !== 1'b1) busy_lost = 1'b1;
      #50;
      i_sclk = 1'b0;
   endtask

   task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], r);
         rx[i] = r;
      end
   endtask

   task automatic cs_start();
      @(negedge clk);
      i_cs_n = 1'b0;
      #60;
   endtask

   task automatic cs_end();
      #60;
      i_cs_n = 1'b1;
      #100;
   endtask

   task automatic send_read(input logic [23:0] a);
      logic [7:0] d;
      spi_xfer(8'h03, d);
      spi_xfer(a[23:16], d);
      spi_xfer(a[15:8], d);
      spi_xfer(a[7:0], d);
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk);
      i_load_we   = 1'b1;
      i_load_addr = a;
      i_load_data = d;
      @(negedge clk);
      i_load_we   = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (o_miso !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_miso got=%b exp=0", o_miso);
      end
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy got=%b exp=0", o_busy);
      end
      #30;
      reset_n = 1'b1;
      #50;
   endtask

   task automatic test_read();
      logic [7:0] exp [4];
      logic [7:0] rx;
      exp = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
      for (int i = 0; i < 4; i++) preload(12'h010 + 12'(i), exp[i]);
      busy_lost = 1'b0;
      cs_start();
      send_read(24'h000010);
      for (int i = 0; i < 4; i++) begin
         spi_xfer(8'h00, rx);
         n_checks++;
         if (rx !== exp[i]) begin
            n_fail++;
            $display("FAIL read_byte%0d got=%h exp=%h", i, rx, exp[i]);
         end
      end
      n_checks++;
      if (busy_lost !== 1'b0) begin
         n_fail++;
         $display("FAIL read_busy_held got_drop=%b exp=0", busy_lost);
      end
      cs_end();
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL read_busy_end got=%b exp=0", o_busy);
      end
   endtask

   task automatic test_wrap();
      logic [23:0] addrs [2];
      logic [7:0]  rx;
      logic [7:0]  exp [2];
      addrs = '{24'h000FFF, 24'h001FFF};
      exp   = '{8'h3C, 8'hC3};
      preload(12'hFFF, 8'h3C);
      preload(12'h000, 8'hC3);
      for (int k = 0; k < 2; k++) begin
         cs_start();
         send_read(addrs[k]);
         for (int i = 0; i < 2; i++) begin
            spi_xfer(8'h00, rx);
            n_checks++;
            if (rx !== exp[i]) begin
               n_fail++;
               $display("FAIL wrap_a%h_b%0d got=%h exp=%h",
                        addrs[k], i, rx, exp[i]);
            end
         end
         cs_end();
      end
   endtask

   task automatic test_rdid_rdsr();
      logic [7:0] exp [3];
      logic [7:0] rx;
      exp = '{8'hEF, 8'h40, 8'h16};
      cs_start();
      spi_xfer(8'h9F, rx);
      for (int i = 0; i < 6; i++) begin
         spi_xfer(8'h00, rx);
         n_checks++;
         if (rx !== exp[i % 3]) begin
            n_fail++;
            $display("FAIL rdid_byte%0d got=%h exp=%h", i, rx, exp[i % 3]);
         end
      end
      cs_end();
      cs_start();
      spi_xfer(8'h05, rx);
      for (int i = 0; i < 2; i++) begin
         spi_xfer(8'hFF, rx);
         n_checks++;
         if (rx !== 8'h00) begin
            n_fail++;
            $display("FAIL rdsr_byte%0d got=%h exp=00", i, rx);
         end
      end
      cs_end();
   endtask

   task automatic test_ignore();
      logic [7:0] rx;
      cs_start();
      spi_xfer(8'hAB, rx);
      for (int i = 0; i < 2; i++) begin
         spi_xfer(8'hFF, rx);
         n_checks++;
         if (rx !== 8'h00) begin
            n_fail++;
            $display("FAIL ignore_byte%0d got=%h exp=00", i, rx);
         end
      end
      cs_end();
      cs_start();
      send_read(24'h000010);
      spi_xfer(8'h00, rx);
      n_checks++;
      if (rx !== 8'hA5) begin
         n_fail++;
         $display("FAIL ignore_recover got=%h exp=a5", rx);
      end
      cs_end();
   endtask

   task automatic do_abort(input logic [23:0] a, input logic [3:0] nib,
                           input logic pre);
      logic [3:0] got;
      logic       r;
      cs_start();
      send_read(a);
      for (int i = 3; i >= 0; i--) begin
         spi_bit(1'b0, r);
         got[i] = r;
      end
      n_checks++;
      if (got !== nib) begin
         n_fail++;
         $display("FAIL abort_nibble_a%h got=%h exp=%h", a, got, nib);
      end
      #40;
      n_checks++;
      if (o_miso !== pre) begin
         n_fail++;
         $display("FAIL abort_pre_miso_a%h got=%b exp=%b", a, o_miso, pre);
      end
      i_cs_n = 1'b1;
      #20;
      n_checks++;
      if (o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_busy_2clk_a%h got=%b exp=1", a, o_busy);
      end
      #10;
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_busy_3clk_a%h got=%b exp=0", a, o_busy);
      end
      n_checks++;
      if (o_miso !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_miso_a%h got=%b exp=0", a, o_miso);
      end
      #100;
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      do_abort(24'h000010, 4'hA, 1'b0);
      do_abort(24'h000012, 4'hF, 1'b1);
      cs_start();
      send_read(24'h000011);
      spi_xfer(8'h00, rx);
      n_checks++;
      if (rx !== 8'h5A) begin
         n_fail++;
         $display("FAIL abort_recover got=%h exp=5a", rx);
      end
      cs_end();
   endtask

   task automatic test_reset_mid();
      logic [7:0] rx;
      logic [7:0] acc;
      cs_start();
      spi_xfer(8'h03, rx);
      spi_xfer(8'h00, rx);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_busy got=%b exp=0", o_busy);
      end
      n_checks++;
      if (o_miso !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_miso got=%b exp=0", o_miso);
      end
      #19;
      reset_n = 1'b1;
      #50;
      send_read(24'h000010);
      spi_xfer(8'h00, rx);
      acc = rx;
      spi_xfer(8'h00, rx);
      acc = acc | rx;
      n_checks++;
      if (acc !== 8'h00) begin
         n_fail++;
         $display("FAIL rstmid_no_resp got=%h exp=00", acc);
      end
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_no_busy got=%b exp=0", o_busy);
      end
      cs_end();
      cs_start();
      send_read(24'h000010);
      spi_xfer(8'h00, rx);
      n_checks++;
      if (rx !== 8'hA5) begin
         n_fail++;
         $display("FAIL rstmid_recover got=%h exp=a5", rx);
      end
      cs_end();
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      busy_lost   = 1'b0;
      reset_n     = 1'b0;
      i_sclk      = 1'b0;
      i_cs_n      = 1'b1;
      i_mosi      = 1'b0;
      i_load_we   = 1'b0;
      i_load_addr = '0;
      i_load_data = '0;
      test_reset();
      test_read();
      test_wrap();
      test_rdid_rdsr();
      test_ignore();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
